// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 command/pixel byte sequencer.
package oled_pkg;

    typedef enum logic [1:0] {
        PWR,
        IDLE,
        XFER,
        GAP
    } state_t;

    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;
    localparam int         INIT_LEN  = 31;

    localparam int BCNT_W = 11;
    localparam int WAIT_W = 16;

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 128x64 power-on command list, indexed by position after the control byte.
module oled_init_rom
    import oled_pkg::*;
(
    input  logic [4:0] index,
    output logic [7:0] data
);

    always_comb begin
        data = 8'h00;
        case (index)
            5'd0:  data = 8'hAE;
            5'd1:  data = 8'hD5;
            5'd2:  data = 8'h80;
            5'd3:  data = 8'hA8;
            5'd4:  data = 8'h3F;
            5'd5:  data = 8'hD3;
            5'd6:  data = 8'h00;
            5'd7:  data = 8'h40;
            5'd8:  data = 8'h8D;
            5'd9:  data = 8'h14;
            5'd10: data = 8'h20;
            5'd11: data = 8'h00;
            5'd12: data = 8'hA1;
            5'd13: data = 8'hC8;
            5'd14: data = 8'hDA;
            5'd15: data = 8'h12;
            5'd16: data = 8'h81;
            5'd17: data = 8'hCF;
            5'd18: data = 8'hD9;
            5'd19: data = 8'hF1;
            5'd20: data = 8'hDB;
            5'd21: data = 8'h40;
            5'd22: data = 8'hA4;
            5'd23: data = 8'hA6;
            5'd24: data = 8'h21;
            5'd25: data = 8'h00;
            5'd26: data = 8'h7F;
            5'd27: data = 8'h22;
            5'd28: data = 8'h00;
            5'd29: data = 8'h07;
            5'd30: data = 8'hAF;
            default: data = 8'h00;
        endcase
    end

endmodule

// File: rtl/oled_cmd_seq.sv
// Feeds the i2c master one byte per next/ack handshake: the init list once after
// power-up, then one full frame of upstream pixel bytes per start_frame request.
module oled_cmd_seq
    import oled_pkg::*;
#(
    parameter logic [7:0] I2C_ADDR   = 8'h78,
    parameter int         PWR_WAIT   = 16,
    parameter int         GAP_CYCLES = 8,
    parameter int         FB_BYTES   = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       next,
    output logic       enable,
    output logic [7:0] command,
    output logic       ack,
    input  logic       start_frame,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       init_done,
    output logic       frame_done,
    output logic       busy
);

    localparam logic [WAIT_W-1:0] PWR_LAST = WAIT_W'(PWR_WAIT - 1);
    localparam logic [WAIT_W-1:0] GAP_LAST = WAIT_W'(GAP_CYCLES - 1);
    localparam logic [BCNT_W-1:0] FB_LEN   = BCNT_W'(FB_BYTES);
    localparam logic [BCNT_W-1:0] ROM_LEN  = BCNT_W'(INIT_LEN);

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   cnt_reg, cnt_next;
    logic [BCNT_W-1:0]   byte_cnt_reg, byte_cnt_next;
    logic                ctrl_sent_reg, ctrl_sent_next;
    logic                hs_pending_reg, hs_pending_next;
    logic                enable_reg, enable_next;
    logic [7:0]          command_reg, command_next;
    logic                ack_reg, ack_next;
    logic                init_done_reg, init_done_next;
    logic                frame_done_reg, frame_done_next;

    logic                is_frame;
    logic                more_bytes;
    logic                pix_byte;
    logic                pix_load;
    logic [BCNT_W-1:0]   xfer_len;
    logic [7:0]          rom_byte;

    oled_init_rom u_rom (
        .index (byte_cnt_reg[4:0]),
        .data  (rom_byte)
    );

    // Init only ever runs before init_done is set, so the flag also selects the byte source.
    assign is_frame   = init_done_reg;
    assign xfer_len   = is_frame ? FB_LEN : ROM_LEN;
    assign more_bytes = !ctrl_sent_reg || (byte_cnt_reg < xfer_len);
    assign pix_byte   = is_frame && ctrl_sent_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= PWR;
            cnt_reg        <= '0;
            byte_cnt_reg   <= '0;
            ctrl_sent_reg  <= 1'b0;
            hs_pending_reg <= 1'b0;
            enable_reg     <= 1'b0;
            command_reg    <= I2C_ADDR;
            ack_reg        <= 1'b0;
            init_done_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            byte_cnt_reg   <= byte_cnt_next;
            ctrl_sent_reg  <= ctrl_sent_next;
            hs_pending_reg <= hs_pending_next;
            enable_reg     <= enable_next;
            command_reg    <= command_next;
            ack_reg        <= ack_next;
            init_done_reg  <= init_done_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        byte_cnt_next   = byte_cnt_reg;
        ctrl_sent_next  = ctrl_sent_reg;
        hs_pending_next = hs_pending_reg;
        enable_next     = enable_reg;
        command_next    = command_reg;
        ack_next        = ack_reg;
        init_done_next  = init_done_reg;
        frame_done_next = 1'b0;
        pix_load        = 1'b0;

        case (state_reg)
            PWR: begin
                if (cnt_reg == PWR_LAST) begin
                    state_next      = XFER;
                    enable_next     = 1'b1;
                    command_next    = I2C_ADDR;
                    byte_cnt_next   = '0;
                    ctrl_sent_next  = 1'b0;
                    hs_pending_next = 1'b0;
                    ack_next        = 1'b0;
                    cnt_next        = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            IDLE: begin
                if (start_frame && init_done_reg) begin
                    state_next      = XFER;
                    enable_next     = 1'b1;
                    command_next    = I2C_ADDR;
                    byte_cnt_next   = '0;
                    ctrl_sent_next  = 1'b0;
                    hs_pending_next = 1'b0;
                    ack_next        = 1'b0;
                    cnt_next        = '0;
                end
            end

            XFER: begin
                // The inter-transaction gap is timed from the edge that drops enable.
                if (!enable_reg) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                if (next && !hs_pending_reg) begin
                    if (!more_bytes) begin
                        enable_next     = 1'b0;
                        hs_pending_next = 1'b1;
                        cnt_next        = '0;
                    end else if (!pix_byte || pix_valid) begin
                        ack_next        = 1'b1;
                        hs_pending_next = 1'b1;
                        if (!ctrl_sent_reg) begin
                            command_next   = is_frame ? CTRL_DATA : CTRL_CMD;
                            ctrl_sent_next = 1'b1;
                        end else begin
                            command_next  = pix_byte ? pix_data : rom_byte;
                            byte_cnt_next = byte_cnt_reg + 1'b1;
                            pix_load      = pix_byte;
                        end
                    end
                end else if (!next && hs_pending_reg) begin
                    ack_next        = 1'b0;
                    hs_pending_next = 1'b0;
                    if (!enable_reg) begin
                        state_next = GAP;
                    end
                end
            end

            GAP: begin
                if (cnt_reg >= GAP_LAST) begin
                    state_next = IDLE;
                    if (init_done_reg) begin
                        frame_done_next = 1'b1;
                    end else begin
                        init_done_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: state_next = PWR;
        endcase
    end

    assign enable     = enable_reg;
    assign command    = command_reg;
    assign ack        = ack_reg;
    assign init_done  = init_done_reg;
    assign frame_done = frame_done_reg;
    assign busy       = (state_reg != IDLE);
    assign pix_ready  = pix_load && !reset;

endmodule
